// File: rtl/mem_align_unit.sv
// Load/store alignment unit in front of a word-wide data RAM: lane steering, sign/zero extension,
// and two-beat splitting of word-crossing accesses. Define MISALIGN_TRAP_EN to trap misaligned requests instead.
module mem_align_unit #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [2:0]            Funct3,
  input  logic [DM_ADDRESS-1:0] a,
  input  logic [DATA_W-1:0]     wd,
  output logic                  rsp_valid,
  output logic                  rsp_err,
  output logic [DATA_W-1:0]     rd,
  output logic [DM_ADDRESS-3:0] dm_addr,
  output logic [3:0]            dm_we,
  output logic [DATA_W-1:0]     dm_wdata,
  input  logic [DATA_W-1:0]     dm_rdata
);

  localparam int AW = DM_ADDRESS - 2;

  typedef enum logic {S_IDLE, S_SECOND} state_t;

  state_t r_state, w_state_nxt;

  function automatic logic [3:0] size_mask(input logic is_load, input logic [2:0] f3);
    logic [3:0] m;
    m = 4'b1111;
    if (is_load) begin
      case (f3)
        3'b000, 3'b100: m = 4'b0001;
        3'b001, 3'b101: m = 4'b0011;
        default:        m = 4'b1111;
      endcase
    end else begin
      case (f3)
        3'b000:  m = 4'b0001;
        3'b001:  m = 4'b0011;
        default: m = 4'b1111;
      endcase
    end
    return m;
  endfunction

  function automatic logic [31:0] rotl_bytes(input logic [31:0] d, input logic [1:0] o);
    logic [31:0] r;
    case (o)
      2'd0:    r = d;
      2'd1:    r = {d[23:0], d[31:24]};
      2'd2:    r = {d[15:0], d[31:16]};
      default: r = {d[7:0],  d[31:8]};
    endcase
    return r;
  endfunction

  // Bytes arrive packed as {upper word, lower word}; shift the first byte of the access down to lane 0.
  function automatic logic [31:0] load_extend(input logic [63:0] v, input logic [1:0] o,
                                              input logic [2:0] f3);
    logic [31:0]        sh;
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] ext;
    sh  = 32'(v >> {o, 3'b000});
    b   = signed'(sh[7:0]);
    h   = signed'(sh[15:0]);
    ext = signed'(sh);
    case (f3)
      3'b000:  ext = b;
      3'b001:  ext = h;
      3'b100:  ext = signed'({24'h0, sh[7:0]});
      3'b101:  ext = signed'({16'h0, sh[15:0]});
      default: ext = signed'(sh);
    endcase
    return unsigned'(ext);
  endfunction

  logic          w_accept;
  logic          w_is_load;
  logic          w_is_store;
  logic [1:0]    w_o;
  logic [AW-1:0] w_word;
  logic [3:0]    w_smask;
  logic [7:0]    w_lanes;
  logic          w_cross;
  logic          w_trap;
  logic [31:0]   w_wrot;

  assign w_accept   = req_valid && req_ready && reset;
  assign w_is_load  = MemRead;
  assign w_is_store = MemWrite && !MemRead;
  assign w_o        = a[1:0];
  assign w_word     = a[DM_ADDRESS-1:2];
  assign w_smask    = size_mask(MemRead, Funct3);
  assign w_lanes    = {4'b0000, w_smask} << w_o;
  assign w_cross    = |w_lanes[7:4];
  assign w_wrot     = rotl_bytes(wd, w_o);

`ifdef MISALIGN_TRAP_EN
  logic w_misalign;
  assign w_misalign = ((w_smask == 4'b0011) && a[0]) || ((w_smask == 4'b1111) && (w_o != 2'd0));
  assign w_trap     = (w_is_load || w_is_store) && w_misalign;
`else
  assign w_trap     = 1'b0;
`endif

  logic          r_rsp_vld_p1;
  logic          r_err_p1;
  logic [31:0]   r_rd_p1;
  logic [31:0]   r_lo;
  logic [AW-1:0] r_word_nxt;
  logic [3:0]    r_we_hi;
  logic [31:0]   r_wdata;
  logic [1:0]    r_o;
  logic [2:0]    r_f3;
  logic          r_is_load;

  always_comb begin
    w_state_nxt = r_state;
    req_ready   = (r_state == S_IDLE);
    dm_addr     = w_word;
    dm_we       = 4'b0000;
    dm_wdata    = w_wrot;
    case (r_state)
      S_IDLE: begin
        if (w_accept && w_is_store && !w_trap)
          dm_we = w_lanes[3:0];
        if (w_accept && (w_is_load || w_is_store) && w_cross && !w_trap)
          w_state_nxt = S_SECOND;
      end
      S_SECOND: begin
        dm_addr     = r_word_nxt;
        dm_we       = r_we_hi;
        dm_wdata    = r_wdata;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // Reset is sampled at the same edge the RAM writes on, so it must also mask the enables.
    if (!reset) begin
      dm_we       = 4'b0000;
      w_state_nxt = S_IDLE;
    end
  end

  // Response stage: registered one cycle after the last RAM beat
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_rsp_vld_p1 <= 1'b0;
      r_err_p1     <= 1'b0;
      r_rd_p1      <= 32'h0;
    end else begin
      r_state      <= w_state_nxt;
      r_rsp_vld_p1 <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept && (w_is_load || w_is_store)) begin
            if (w_trap) begin
              r_rsp_vld_p1 <= 1'b1;
              r_err_p1     <= 1'b1;
            end else if (!w_cross) begin
              r_rsp_vld_p1 <= 1'b1;
              r_err_p1     <= 1'b0;
              if (w_is_load)
                r_rd_p1 <= load_extend({32'h0, dm_rdata}, w_o, Funct3);
            end
          end
        end
        S_SECOND: begin
          r_rsp_vld_p1 <= 1'b1;
          r_err_p1     <= 1'b0;
          if (r_is_load)
            r_rd_p1 <= load_extend({dm_rdata, r_lo}, r_o, r_f3);
        end
        default: r_rsp_vld_p1 <= 1'b0;
      endcase
    end
  end

  // Split context: first-beat data and everything the second beat needs
  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && w_accept) begin
      r_lo       <= dm_rdata;
      r_word_nxt <= w_word + AW'(1);
      r_we_hi    <= w_is_store ? w_lanes[7:4] : 4'b0000;
      r_wdata    <= w_wrot;
      r_o        <= w_o;
      r_f3       <= Funct3;
      r_is_load  <= w_is_load;
    end
  end

  assign rsp_valid = r_rsp_vld_p1;
  assign rd        = r_rd_p1;
`ifdef MISALIGN_TRAP_EN
  assign rsp_err   = r_err_p1;
`else
  assign rsp_err   = r_err_p1 & 1'b0;
`endif

endmodule

// File: tb/tb_mem_align_unit.sv
// Directed bench for mem_align_unit with a behavioural word RAM; expected values are hand-computed
// from the preloaded RAM image.
module tb_mem_align_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, MemRead, MemWrite;
  logic [2:0]  Funct3;
  logic [8:0]  a;
  logic [31:0] wd, rd, dm_wdata, dm_rdata;
  logic        rsp_valid, rsp_err;
  logic [6:0]  dm_addr;
  logic [3:0]  dm_we;

  logic [31:0] mem [128];
  logic        pl_en;
  logic [6:0]  pl_idx;
  logic [31:0] pl_val;

  int vec  = 0;
  int errs = 0;
  logic [31:0] exp_rd;

  always #5 clk = ~clk;

  mem_align_unit #(.DM_ADDRESS(9), .DATA_W(32)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .MemRead(MemRead), .MemWrite(MemWrite), .Funct3(Funct3), .a(a), .wd(wd),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rd(rd),
    .dm_addr(dm_addr), .dm_we(dm_we), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata)
  );

  assign dm_rdata = mem[dm_addr];

  always @(posedge clk) begin
    if (pl_en) mem[pl_idx] <= pl_val;
    for (int i = 0; i < 4; i++)
      if (dm_we[i]) mem[dm_addr][8*i +: 8] <= dm_wdata[8*i +: 8];
  end

  task automatic idle_inputs();
    req_valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
    Funct3 = 3'b000; a = 9'h0; wd = 32'h0;
  endtask

  task automatic preload(input logic [6:0] idx, input logic [31:0] val);
    @(negedge clk); pl_en = 1'b1; pl_idx = idx; pl_val = val;
    @(negedge clk); pl_en = 1'b0;
  endtask

  task automatic do_load(input logic [2:0] f3, input logic [8:0] addr, input logic [31:0] exp,
                         input string nm);
    @(negedge clk);
    req_valid = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; Funct3 = f3; a = addr;
    #1;
    vec++; if (dm_addr !== addr[8:2]) begin errs++; $display("FAIL %s dm_addr got %h want %h", nm, dm_addr, addr[8:2]); end
    vec++; if (req_ready !== 1'b1) begin errs++; $display("FAIL %s req_ready got %b want 1", nm, req_ready); end
    @(negedge clk); idle_inputs();
    vec++; if (rsp_valid !== 1'b1) begin errs++; $display("FAIL %s rsp_valid got %b want 1", nm, rsp_valid); end
    vec++; if (rd !== exp) begin errs++; $display("FAIL %s rd got %h want %h", nm, rd, exp); end
    vec++; if (rsp_err !== 1'b0) begin errs++; $display("FAIL %s rsp_err got %b want 0", nm, rsp_err); end
    exp_rd = exp;
  endtask

  task automatic test_reset();
    reset = 1'b0; pl_en = 1'b0; idle_inputs();
    preload(7'd0,   32'h44332211);
    preload(7'd1,   32'h88776655);
    preload(7'd3,   32'hCAFEF00D);
    preload(7'd127, 32'hDDCCBBAA);
    #1;
    vec++; if (rsp_valid !== 1'b0) begin errs++; $display("FAIL reset rsp_valid got %b want 0", rsp_valid); end
    vec++; if (rsp_err !== 1'b0) begin errs++; $display("FAIL reset rsp_err got %b want 0", rsp_err); end
    vec++; if (rd !== 32'h0) begin errs++; $display("FAIL reset rd got %h want 0", rd); end
    vec++; if (dm_we !== 4'b0000) begin errs++; $display("FAIL reset dm_we got %b want 0000", dm_we); end
    vec++; if (req_ready !== 1'b1) begin errs++; $display("FAIL reset req_ready got %b want 1", req_ready); end
    @(negedge clk); reset = 1'b1;
    exp_rd = 32'h0;
  endtask

  task automatic test_aligned();
    do_load(3'b010, 9'h000, 32'h44332211, "lw_a0");
  endtask

  task automatic test_byte_half();
    do_load(3'b000, 9'h007, 32'hFFFFFF88, "lb_a7");
    do_load(3'b100, 9'h007, 32'h00000088, "lbu_a7");
    do_load(3'b001, 9'h005, 32'h00007766, "lh_a5");
    do_load(3'b101, 9'h006, 32'h00008877, "lhu_a6");
  endtask

  task automatic test_cross_load();
    @(negedge clk);
    req_valid = 1'b1; MemRead = 1'b1; Funct3 = 3'b010; a = 9'h002;
    #1;
    vec++; if (dm_addr !== 7'd0) begin errs++; $display("FAIL xlw beat1 dm_addr got %h want 0", dm_addr); end
    @(negedge clk); idle_inputs();
    vec++; if (req_ready !== 1'b0) begin errs++; $display("FAIL xlw req_ready got %b want 0", req_ready); end
    vec++; if (dm_addr !== 7'd1) begin errs++; $display("FAIL xlw beat2 dm_addr got %h want 1", dm_addr); end
    vec++; if (rsp_valid !== 1'b0) begin errs++; $display("FAIL xlw early rsp_valid got %b want 0", rsp_valid); end
    @(negedge clk);
    vec++; if (rsp_valid !== 1'b1) begin errs++; $display("FAIL xlw rsp_valid got %b want 1", rsp_valid); end
    vec++; if (rd !== 32'h66554433) begin errs++; $display("FAIL xlw rd got %h want 66554433", rd); end
    vec++; if (req_ready !== 1'b1) begin errs++; $display("FAIL xlw req_ready after got %b want 1", req_ready); end
    exp_rd = 32'h66554433;
  endtask

  task automatic test_cross_store();
    @(negedge clk);
    req_valid = 1'b1; MemWrite = 1'b1; Funct3 = 3'b001; a = 9'h003; wd = 32'h0000BEEF;
    #1;
    vec++; if (dm_we !== 4'b1000) begin errs++; $display("FAIL sh beat1 dm_we got %b want 1000", dm_we); end
    vec++; if (dm_wdata !== 32'hEF0000BE) begin errs++; $display("FAIL sh dm_wdata got %h want ef0000be", dm_wdata); end
    @(negedge clk); idle_inputs();
    vec++; if (dm_we !== 4'b0001) begin errs++; $display("FAIL sh beat2 dm_we got %b want 0001", dm_we); end
    vec++; if (dm_addr !== 7'd1) begin errs++; $display("FAIL sh beat2 dm_addr got %h want 1", dm_addr); end
    @(negedge clk);
    vec++; if (rsp_valid !== 1'b1) begin errs++; $display("FAIL sh rsp_valid got %b want 1", rsp_valid); end
    vec++; if (rd !== exp_rd) begin errs++; $display("FAIL sh rd kept got %h want %h", rd, exp_rd); end
    vec++; if (mem[0] !== 32'hEF332211) begin errs++; $display("FAIL sh word0 got %h want ef332211", mem[0]); end
    vec++; if (mem[1] !== 32'h887766BE) begin errs++; $display("FAIL sh word1 got %h want 887766be", mem[1]); end
  endtask

  task automatic test_wrap();
    @(negedge clk);
    req_valid = 1'b1; MemRead = 1'b1; Funct3 = 3'b010; a = 9'h1FE;
    #1;
    vec++; if (dm_addr !== 7'd127) begin errs++; $display("FAIL wrap beat1 dm_addr got %h want 7f", dm_addr); end
    @(negedge clk); idle_inputs();
    vec++; if (dm_addr !== 7'd0) begin errs++; $display("FAIL wrap beat2 dm_addr got %h want 0", dm_addr); end
    @(negedge clk);
    vec++; if (rd !== 32'h2211DDCC) begin errs++; $display("FAIL wrap rd got %h want 2211ddcc", rd); end
    exp_rd = 32'h2211DDCC;
  endtask

  task automatic test_byte_store();
    @(negedge clk);
    req_valid = 1'b1; MemWrite = 1'b1; Funct3 = 3'b000; a = 9'h00D; wd = 32'h000000AB;
    #1;
    vec++; if (dm_we !== 4'b0010) begin errs++; $display("FAIL sb dm_we got %b want 0010", dm_we); end
    vec++; if (dm_wdata !== 32'h0000AB00) begin errs++; $display("FAIL sb dm_wdata got %h want 0000ab00", dm_wdata); end
    @(negedge clk); idle_inputs();
    vec++; if (rsp_valid !== 1'b1) begin errs++; $display("FAIL sb rsp_valid got %b want 1", rsp_valid); end
    vec++; if (rd !== exp_rd) begin errs++; $display("FAIL sb rd kept got %h want %h", rd, exp_rd); end
    vec++; if (mem[3] !== 32'hCAFEAB0D) begin errs++; $display("FAIL sb word3 got %h want cafeab0d", mem[3]); end
    do_load(3'b100, 9'h00D, 32'h000000AB, "lbu_a13");
    do_load(3'b000, 9'h00D, 32'hFFFFFFAB, "lb_a13");
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    req_valid = 1'b1; MemRead = 1'b1; Funct3 = 3'b010; a = 9'h00C;
    @(negedge clk);
    a = 9'h1FC;
    #1;
    vec++; if (rsp_valid !== 1'b1) begin errs++; $display("FAIL b2b first rsp_valid got %b want 1", rsp_valid); end
    vec++; if (rd !== 32'hCAFEAB0D) begin errs++; $display("FAIL b2b first rd got %h want cafeab0d", rd); end
    vec++; if (req_ready !== 1'b1) begin errs++; $display("FAIL b2b req_ready got %b want 1", req_ready); end
    @(negedge clk); idle_inputs();
    vec++; if (rsp_valid !== 1'b1) begin errs++; $display("FAIL b2b second rsp_valid got %b want 1", rsp_valid); end
    vec++; if (rd !== 32'hDDCCBBAA) begin errs++; $display("FAIL b2b second rd got %h want ddccbbaa", rd); end
    exp_rd = 32'hDDCCBBAA;
  endtask

  task automatic test_reset_second();
    preload(7'd0, 32'h44332211);
    preload(7'd1, 32'h88776655);
    @(negedge clk);
    req_valid = 1'b1; MemWrite = 1'b1; Funct3 = 3'b010; a = 9'h001; wd = 32'h11223344;
    #1;
    vec++; if (dm_we !== 4'b1110) begin errs++; $display("FAIL rst2 beat1 dm_we got %b want 1110", dm_we); end
    @(negedge clk); idle_inputs(); reset = 1'b0;
    #1;
    vec++; if (dm_we !== 4'b0000) begin errs++; $display("FAIL rst2 suppressed dm_we got %b want 0000", dm_we); end
    @(negedge clk);
    vec++; if (rsp_valid !== 1'b0) begin errs++; $display("FAIL rst2 rsp_valid got %b want 0", rsp_valid); end
    vec++; if (rd !== 32'h0) begin errs++; $display("FAIL rst2 rd got %h want 0", rd); end
    vec++; if (req_ready !== 1'b1) begin errs++; $display("FAIL rst2 req_ready got %b want 1", req_ready); end
    vec++; if (mem[0] !== 32'h22334411) begin errs++; $display("FAIL rst2 word0 got %h want 22334411", mem[0]); end
    vec++; if (mem[1] !== 32'h88776655) begin errs++; $display("FAIL rst2 word1 got %h want 88776655", mem[1]); end
    reset = 1'b1;
    @(negedge clk);
    vec++; if (rsp_valid !== 1'b0) begin errs++; $display("FAIL rst2 late rsp_valid got %b want 0", rsp_valid); end
    exp_rd = 32'h0;
  endtask

  task automatic test_trap();
    @(negedge clk);
    req_valid = 1'b1; MemWrite = 1'b1; Funct3 = 3'b010; a = 9'h002; wd = 32'h12345678;
    #1;
    vec++; if (dm_we !== 4'b0000) begin errs++; $display("FAIL trap sw dm_we got %b want 0000", dm_we); end
    @(negedge clk); idle_inputs();
    vec++; if (rsp_valid !== 1'b1) begin errs++; $display("FAIL trap sw rsp_valid got %b want 1", rsp_valid); end
    vec++; if (rsp_err !== 1'b1) begin errs++; $display("FAIL trap sw rsp_err got %b want 1", rsp_err); end
    vec++; if (mem[0] !== 32'h44332211) begin errs++; $display("FAIL trap word0 got %h want 44332211", mem[0]); end
    @(negedge clk);
    req_valid = 1'b1; MemRead = 1'b1; Funct3 = 3'b010; a = 9'h002;
    @(negedge clk); idle_inputs();
    vec++; if (rsp_err !== 1'b1) begin errs++; $display("FAIL trap lw rsp_err got %b want 1", rsp_err); end
    vec++; if (rd !== exp_rd) begin errs++; $display("FAIL trap lw rd kept got %h want %h", rd, exp_rd); end
    @(negedge clk);
    req_valid = 1'b1; MemRead = 1'b1; Funct3 = 3'b001; a = 9'h005;
    #1;
    vec++; if (req_ready !== 1'b1) begin errs++; $display("FAIL trap lh req_ready got %b want 1", req_ready); end
    @(negedge clk); idle_inputs();
    vec++; if (rsp_err !== 1'b1) begin errs++; $display("FAIL trap lh rsp_err got %b want 1", rsp_err); end
    do_load(3'b010, 9'h004, 32'h88776655, "trap_lw_aligned");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_aligned();
    test_byte_half();
`ifdef MISALIGN_TRAP_EN
    test_byte_store();
    test_back_to_back();
    test_trap();
`else
    test_cross_load();
    test_cross_store();
    test_wrap();
    test_byte_store();
    test_back_to_back();
    test_reset_second();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule

// File: doc/mem_align_unit.md
Name: mem_align_unit

Overview:
- Load/store access unit directly upstream of the data memory; receives MEM-stage requests (MemRead/MemWrite, Funct3, byte address, store data).
- Drives a word-wide RAM port with per-byte write enables.
- Handles LB/LH/LW/LBU/LHU alignment, sign/zero extension and byte-lane steering.
- Splits word-crossing accesses into two sequential word accesses and back-pressures the pipeline while it does so.

Parameters:
DM_ADDRESS, 9, byte-address width; RAM holds 2^(DM_ADDRESS-2) words
DATA_W, 32, data width; fixed at 32, other values unsupported

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous active-low reset
req_valid  input  1  request present this cycle
req_ready  output  1  unit can accept a request this cycle
MemRead  input  1  load request (from control unit)
MemWrite  input  1  store request (from control unit)
Funct3  input  3  access size/sign, instruction bits 14:12
a  input  DM_ADDRESS  byte address
wd  input  DATA_W  store data, LSB-justified
rsp_valid  output  1  one-cycle pulse: load data valid / store complete
rsp_err  output  1  misaligned-trap flag, qualified by rsp_valid (optional feature)
rd  output  DATA_W  extended load data, held until next rsp_valid
dm_addr  output  DM_ADDRESS-2  RAM word index
dm_we  output  4  RAM byte write enables, lane i = bits 8i+7:8i
dm_wdata  output  DATA_W  RAM write data
dm_rdata  input  DATA_W  RAM read data, combinational from dm_addr

Behaviour:
- Reset (reset==0 at a clk edge):
  - state=IDLE; rsp_valid=0, rsp_err=0, rd=0, dm_we=0, req_ready=1.
- Transaction accept:
  - Request accepted when req_valid && req_ready.
  - MemRead has priority if both MemRead and MemWrite are set.
  - Neither set: accepted as a no-op, no RAM access, no response.
- Size s from Funct3:
  - 000/100 → s=1; 001/101 → s=2; 010 → s=4.
  - Loads 011/110/111 treated as LW; stores other than 000/001 treated as SW.
- Byte lanes:
  - o=a[1:0]; access covers lanes o..o+s-1.
  - Lanes <4 fall in word w=a[DM_ADDRESS-1:2]; lanes ≥4 fall in word w+1.
  - w+1 wraps modulo 2^(DM_ADDRESS-2).
  - Crossing condition: o+s>4.
- Store data: dm_wdata = wd rotated left by 8*o bits; the same rotated value is used for both words of a split.
- IDLE:
  - req_ready=1; dm_addr=w combinationally; dm_we = enables for first-word lanes on an accepted store, else 0.
  - Load: capture dm_rdata into lo register.
  - Not crossing: register response; rsp_valid=1 next cycle; stay IDLE.
  - Crossing: go to SECOND.
- SECOND:
  - req_ready=0; dm_addr=w+1 (registered); dm_we = enables for lanes ≥4 mapped to lane-4, stores only.
  - Load: form the 64-bit value {dm_rdata, lo}, shift right 8*o, take s bytes.
  - Register response; rsp_valid=1 next cycle; return to IDLE.
- Latency:
  - Aligned/non-crossing: 1 cycle from accept to rsp_valid.
  - Crossing: 2 cycles; exactly one cycle with req_ready=0.
- Extension:
  - 000 sign-extends bit 7; 001 sign-extends bit 15.
  - 100/101 zero-extend; word loads unchanged.
- rd on a store response: unchanged.
- Back-to-back: a new request may be accepted in the same cycle rsp_valid is high.
- Reset in SECOND:
  - Returns to IDLE; the second-word write is suppressed; no rsp_valid.
  - First-word bytes already written stay written.

Optional Feature:
- Macro MISALIGN_TRAP_EN.
- Defined: any request with a misaligned address (a[0]!=0 for s=2, a[1:0]!=0 for s=4) performs no RAM access (dm_we=0). It returns rsp_valid=1, rsp_err=1 one cycle later, with rd unchanged; SECOND is unreachable.
- Undefined: misaligned requests are split as above; rsp_err is tied to 0.

Test Plan:
- RAM word0=0x44332211, word1=0x88776655; LW a=0 → rsp_valid next cycle, rd=0x44332211, req_ready stays 1.
- LB a=7 → rd=0xFFFFFF88; LBU a=7 → 0x00000088; LH a=5 → 0x00007766; LHU a=6 → 0x00008877.
- LW a=2 → dm_addr 0 then 1, req_ready low one cycle, rsp_valid 2 cycles after accept, rd=0x66554433.
- SH a=3 wd=0x0000BEEF → dm_we=1000 @word0, then 0001 @word1; RAM becomes 0x EF332211 / 0x887766BE.
- LW a=0x1FE (last word, o=2) → second access dm_addr=0 (wrap), rd={word0[15:0],word127[31:16]}.
- SW a=1 then reset low during SECOND → no second write, rsp_valid stays 0, outputs at reset values; with MISALIGN_TRAP_EN, LW a=2 → dm_we=0, rsp_err=1 one cycle later.
